// File: rtl/taxi_eth_pkg.sv
// Shared Ethernet header constants and helpers for frame rewriters.
package taxi_eth_pkg;

    localparam int ETH_HDR_DST_OFF  = 0;
    localparam int ETH_HDR_SRC_OFF  = 6;
    localparam int ETH_MAC_LEN      = 6;
    localparam int ETH_MIN_SWAP_LEN = 12;

    typedef logic [47:0] eth_mac_t;

    // A frame is a runt when it ends on beat0, or ends on beat1 before both MACs are complete.
    function automatic logic eth_is_runt(input logic first_beat, input logic second_beat,
                                         input logic last_beat, input logic [7:0] keep);
        logic [7:0] need;
        need = 8'((1 << (ETH_MIN_SWAP_LEN - 8)) - 1);
        return last_beat && (first_beat || (second_beat && ((keep & need) != need)));
    endfunction

endpackage

// File: rtl/taxi_axis_beat_pipe.sv
// Two-entry beat pipeline (head presented downstream, tail as skid slot).
// head_hold lets the owner keep the head beat back until it has seen the tail beat.
module taxi_axis_beat_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         in_xfer,
    input  logic         head_hold,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic [W-1:0] tail_data,
    output logic         tail_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_xfer
);

    logic         head_valid_reg;
    logic         tail_valid_reg;
    logic [W-1:0] head_data_reg;
    logic [W-1:0] tail_data_reg;

    // Ready depends only on occupancy and the downstream transfer, never on in_valid.
    assign out_valid  = head_valid_reg && !head_hold;
    assign out_xfer   = out_valid && out_ready;
    assign in_ready   = rst_n && (!tail_valid_reg || out_xfer);
    assign in_xfer    = in_valid && in_ready;
    assign head_data  = head_data_reg;
    assign head_valid = head_valid_reg;
    assign tail_data  = tail_data_reg;
    assign tail_valid = tail_valid_reg;

    // Occupancy: shift tail into head on a head transfer, fill the first free slot on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_reg <= 1'b0;
            tail_valid_reg <= 1'b0;
        end else if (out_xfer) begin
            if (tail_valid_reg) begin
                head_valid_reg <= 1'b1;
                tail_valid_reg <= in_xfer;
            end else begin
                head_valid_reg <= in_xfer;
                tail_valid_reg <= 1'b0;
            end
        end else if (in_xfer) begin
            if (!head_valid_reg) begin
                head_valid_reg <= 1'b1;
            end else begin
                tail_valid_reg <= 1'b1;
            end
        end
    end

    // Beat storage follows the same moves as the valid bits; contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (out_xfer) begin
            if (tail_valid_reg) begin
                head_data_reg <= tail_data_reg;
                if (in_xfer) begin
                    tail_data_reg <= in_data;
                end
            end else if (in_xfer) begin
                head_data_reg <= in_data;
            end
        end else if (in_xfer) begin
            if (!head_valid_reg) begin
                head_data_reg <= in_data;
            end else begin
                tail_data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/taxi_eth_mac_swap.sv
// Loopback header rewriter: exchanges destination and source MAC of every frame.
// Optional build macro TAXI_ETH_SWAP_MCAST_PASS_EN: multicast/broadcast frames pass unswapped.
module taxi_eth_mac_swap
    import taxi_eth_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W/8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [ID_W-1:0]   s_axis_tid,
    input  logic [USER_W-1:0] s_axis_tuser,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              stat_runt
);

    if (DATA_W != 64) begin : g_bad_width
        $error("taxi_eth_mac_swap: only DATA_W=64 is supported");
    end

    // Beat word: {data, keep, id, user, last, first, second, runt}
    localparam int PW       = DATA_W + KEEP_W + ID_W + USER_W + 4;
    localparam int MAC_BITS = 8 * ETH_MAC_LEN;
    localparam int HI_BITS  = 8 * (ETH_MIN_SWAP_LEN - 8);

    logic [1:0]    beat_cnt_reg;
    logic          in_first;
    logic          in_second;
    logic          in_runt;
    logic          in_xfer;
    logic [PW-1:0] in_word;
    logic [PW-1:0] head_word;
    logic [PW-1:0] tail_word;
    logic          head_valid;
    logic          tail_valid;
    logic          head_hold;
    logic          out_xfer;

    logic [DATA_W-1:0] hd_data;
    logic [KEEP_W-1:0] hd_keep;
    logic [ID_W-1:0]   hd_id;
    logic [USER_W-1:0] hd_user;
    logic              hd_last, hd_first, hd_second, hd_runt;
    logic              tl_runt;
    logic [HI_BITS-1:0] tl_lo;
    logic              unused_tail;

    eth_mac_t           dst_mac;
    eth_mac_t           src_mac;
    logic               mcast;
    logic               swap_now;
    logic               saved_swap_reg;
    logic [HI_BITS-1:0] saved_dst_hi_reg;

    assign in_first  = (beat_cnt_reg == 2'd0);
    assign in_second = (beat_cnt_reg == 2'd1);
    assign in_runt   = eth_is_runt(in_first, in_second, s_axis_tlast, s_axis_tkeep[7:0]);
    assign in_word   = {s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tuser,
                        s_axis_tlast, in_first, in_second, in_runt};

    // Input-side beat position: 0 = beat0, 1 = beat1, 2 = any later beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= 2'd0;
        end else if (in_xfer) begin
            if (s_axis_tlast) begin
                beat_cnt_reg <= 2'd0;
            end else if (beat_cnt_reg != 2'd2) begin
                beat_cnt_reg <= beat_cnt_reg + 2'd1;
            end
        end
    end

    assign {hd_data, hd_keep, hd_id, hd_user, hd_last, hd_first, hd_second, hd_runt} = head_word;
    assign tl_lo       = tail_word[PW-DATA_W +: HI_BITS];
    assign tl_runt     = tail_word[0];
    assign unused_tail = ^{tail_word[PW-1:PW-DATA_W+HI_BITS], tail_word[PW-DATA_W-1:1]};

    // beat0 waits for beat1 so the whole source MAC is visible before it leaves.
    assign head_hold = head_valid && hd_first && !hd_last && !tail_valid;

    taxi_axis_beat_pipe #(
        .W(PW)
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_word),
        .in_valid   (s_axis_tvalid),
        .in_ready   (s_axis_tready),
        .in_xfer    (in_xfer),
        .head_hold  (head_hold),
        .head_data  (head_word),
        .head_valid (head_valid),
        .tail_data  (tail_word),
        .tail_valid (tail_valid),
        .out_valid  (m_axis_tvalid),
        .out_ready  (m_axis_tready),
        .out_xfer   (out_xfer)
    );

    assign dst_mac = hd_data[8*ETH_HDR_DST_OFF +: MAC_BITS];
    assign src_mac = {tl_lo, hd_data[8*ETH_HDR_SRC_OFF +: DATA_W-8*ETH_HDR_SRC_OFF]};

`ifdef TAXI_ETH_SWAP_MCAST_PASS_EN
    assign mcast = hd_data[8*ETH_HDR_DST_OFF];
`else
    assign mcast = 1'b0;
`endif

    // Swap only a full-header beat0 whose frame is not a runt.
    assign swap_now = hd_first && !hd_last && tail_valid && !tl_runt && !mcast;

    // Remember the upper destination bytes for beat1, which follows beat0 out of the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_swap_reg   <= 1'b0;
            saved_dst_hi_reg <= '0;
        end else if (out_xfer && hd_first) begin
            saved_swap_reg   <= swap_now;
            saved_dst_hi_reg <= dst_mac[MAC_BITS-1:MAC_BITS-HI_BITS];
        end
    end

    // Output mux: beat0 gets {dst[0:1], src}, beat1 low bytes get dst[2:5].
    always_comb begin
        m_axis_tdata = hd_data;
        if (swap_now) begin
            m_axis_tdata[MAC_BITS-1:0]      = src_mac;
            m_axis_tdata[DATA_W-1:MAC_BITS] = dst_mac[DATA_W-MAC_BITS-1:0];
        end else if (hd_second && saved_swap_reg) begin
            m_axis_tdata[HI_BITS-1:0] = saved_dst_hi_reg;
        end
    end

    // Sideband travels with the beat; runt last beats are marked bad.
    always_comb begin
        m_axis_tkeep    = hd_keep;
        m_axis_tid      = hd_id;
        m_axis_tlast    = hd_last;
        m_axis_tuser    = hd_user;
        m_axis_tuser[0] = hd_user[0] | hd_runt;
    end

    assign stat_runt = out_xfer && hd_runt;

endmodule
